alu_pipe: RTL and testbench

//  Registered, handshaked successor of the datapath ALU: WIDTH-generic, one op in flight.

---
 rtl/alu_pipe.sv | 158 +++++++++++++++
 tb/tb_alu_pipe.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// Registered valid/ready ALU, one operation in flight, result held until consumed.
// Define ALU_PIPE_MUL_EN to build the iterative shift-add multiplier; otherwise MUL is reserved.
module alu_pipe #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic [SHW-1:0]   shamt,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             zero
);

   localparam logic [3:0] OpAnd = 4'd0;
   localparam logic [3:0] OpOr  = 4'd1;
   localparam logic [3:0] OpAdd = 4'd2;
   localparam logic [3:0] OpSub = 4'd3;
   localparam logic [3:0] OpSlt = 4'd4;
   localparam logic [3:0] OpNe  = 4'd5;
   localparam logic [3:0] OpSll = 4'd6;
   localparam logic [3:0] OpSra = 4'd7;
`ifdef ALU_PIPE_MUL_EN
   localparam logic [3:0] OpMul = 4'd8;
`endif

   typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic             zero_q, zero_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] alu_res;
   logic             accept;

`ifdef ALU_PIPE_MUL_EN
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [SHW-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0] partial;
`endif

   assign in_ready  = ~rst & (state_q != StMul) & (~out_valid_q | out_ready);
   assign accept    = in_valid & in_ready;
   assign out_valid = out_valid_q;
   assign out       = out_q;
   assign zero      = zero_q;

   // Reserved ops (and MUL without the multiplier) fall through to zero.
   always_comb begin
      alu_res = '0;
      case (op)
         OpAnd:   alu_res = in1 & in2;
         OpOr:    alu_res = in1 | in2;
         OpAdd:   alu_res = in1 + in2;
         OpSub:   alu_res = in1 - in2;
         OpSlt:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(in1) < $signed(in2))};
         OpNe:    alu_res = {{(WIDTH-1){1'b0}}, (in1 != in2)};
         OpSll:   alu_res = in2 << shamt;
         OpSra:   alu_res = $signed(in2) >>> shamt;
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      out_d       = out_q;
      zero_d      = zero_q;
      out_valid_d = out_valid_q;
`ifdef ALU_PIPE_MUL_EN
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      partial  = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif
      case (state_q)
         StIdle, StDone: begin
            if (state_q == StDone && out_ready) begin
               out_valid_d = 1'b0;
               state_d     = StIdle;
            end
            if (accept) begin
`ifdef ALU_PIPE_MUL_EN
               if (op == OpMul) begin
                  acc_d       = '0;
                  mcand_d     = in1;
                  mplier_d    = in2;
                  cnt_d       = '0;
                  out_valid_d = 1'b0;
                  state_d     = StMul;
               end else begin
                  out_d       = alu_res;
                  zero_d      = (alu_res == '0);
                  out_valid_d = 1'b1;
                  state_d     = StDone;
               end
`else
               out_d       = alu_res;
               zero_d      = (alu_res == '0);
               out_valid_d = 1'b1;
               state_d     = StDone;
`endif
            end
         end
`ifdef ALU_PIPE_MUL_EN
         // One multiplier bit per clock; the last step writes the result directly.
         StMul: begin
            acc_d    = partial;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == SHW'(WIDTH - 1)) begin
               out_d       = partial;
               zero_d      = (partial == '0);
               out_valid_d = 1'b1;
               state_d     = StDone;
            end
         end
`endif
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         out_q       <= '0;
         zero_q      <= 1'b1;
         out_valid_q <= 1'b0;
`ifdef ALU_PIPE_MUL_EN
         acc_q       <= '0;
         mcand_q     <= '0;
         mplier_q    <= '0;
         cnt_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         out_q       <= out_d;
         zero_q      <= zero_d;
         out_valid_q <= out_valid_d;
`ifdef ALU_PIPE_MUL_EN
         acc_q       <= acc_d;
         mcand_q     <= mcand_d;
         mplier_q    <= mplier_d;
         cnt_q       <= cnt_d;
`endif
      end
   end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed cases followed by random ops against a reference model.
module tb_alu_pipe;

   localparam int unsigned W   = 32;
   localparam int unsigned SHW = $clog2(W);
`ifdef ALU_PIPE_MUL_EN
   localparam bit MulEn = 1'b1;
`else
   localparam bit MulEn = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           rst;
   logic           in_valid;
   logic           in_ready;
   logic [3:0]     op;
   logic [W-1:0]   in1;
   logic [W-1:0]   in2;
   logic [SHW-1:0] shamt;
   logic           out_valid;
   logic           out_ready;
   logic [W-1:0]   out;
   logic           zero;

   int checks = 0;
   int errors = 0;

   alu_pipe #(.WIDTH(W), .SHW(SHW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .in1       (in1),
      .in2       (in2),
      .shamt     (shamt),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .zero      (zero)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] model(input logic [3:0] o, input logic [W-1:0] a,
                                          input logic [W-1:0] b, input int sh);
      logic [W-1:0]   ones;
      logic [2*W-1:0] prod;
      ones = '1;
      case (o)
         4'd0: return a & b;
         4'd1: return a | b;
         4'd2: return a + b;
         4'd3: return a - b;
         4'd4: return (longint'($signed(a)) < longint'($signed(b))) ? W'(1) : W'(0);
         4'd5: return (a != b) ? W'(1) : W'(0);
         4'd6: return b << sh;
         4'd7: return (b >> sh) | (b[W-1] ? ~(ones >> sh) : '0);
         4'd8: begin
            prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
            return MulEn ? prod[W-1:0] : '0;
         end
         default: return '0;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Presents one op, waits for its result, optionally stalls the consumer, then pops.
   task automatic run_op(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int sh, input int stall, input string tag);
      logic [W-1:0] e;
      int           w;
      int           el;
      e  = model(o, a, b, sh);
      el = (MulEn && o == 4'd8) ? W : 0;
      op = o; in1 = a; in2 = b; shamt = SHW'(sh); in_valid = 1'b1;
      out_ready = (stall == 0);
      chk({tag, "_rdy"}, 64'(in_ready), 64'(1));
      @(negedge clk);
      in_valid = 1'b0;
      op = 4'($urandom); in1 = $urandom; in2 = $urandom; shamt = SHW'($urandom);
      w = 0;
      while (out_valid !== 1'b1 && w < 100) begin
         @(negedge clk);
         w++;
      end
      chk({tag, "_lat"}, 64'(w), 64'(el));
      chk({tag, "_out"}, 64'(out), 64'(e));
      chk({tag, "_zero"}, 64'(zero), 64'(e == '0));
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         chk({tag, "_hold"}, 64'(out), 64'(e));
         chk({tag, "_blk"}, 64'(in_ready), 64'(0));
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk({tag, "_pop"}, 64'(out_valid), 64'(0));
      out_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      op = '0; in1 = '0; in2 = '0; shamt = '0;
      repeat (2) @(negedge clk);
      chk("rst_valid", 64'(out_valid), 64'(0));
      chk("rst_out", 64'(out), 64'(0));
      chk("rst_zero", 64'(zero), 64'(1));
      rst = 1'b0;
      @(negedge clk);
      chk("rst_ready", 64'(in_ready), 64'(1));

      run_op(4'd2, 32'h7FFF_FFFF, 32'h0000_0001, 0, 0, "add_ovf");

      // Back-to-back SUB then SLT with the consumer always ready.
      op = 4'd3; in1 = 32'd5; in2 = 32'd5; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      chk("b2b_sub_v", 64'(out_valid), 64'(1));
      chk("b2b_sub_out", 64'(out), 64'(0));
      chk("b2b_sub_z", 64'(zero), 64'(1));
      chk("b2b_rdy", 64'(in_ready), 64'(1));
      op = 4'd4; in1 = 32'hFFFF_FFFF; in2 = 32'h0000_0001;
      @(negedge clk);
      chk("b2b_slt_v", 64'(out_valid), 64'(1));
      chk("b2b_slt_out", 64'(out), 64'(1));
      chk("b2b_slt_z", 64'(zero), 64'(0));
      in_valid = 1'b0;
      @(negedge clk);
      chk("b2b_pop", 64'(out_valid), 64'(0));
      out_ready = 1'b0;

      run_op(4'd7, 32'h8000_0000, 32'h8000_0000, 4, 0, "sra");
      run_op(4'd6, 32'h0, 32'h0000_0001, 31, 0, "sll");
      run_op(4'd7, 32'h0, 32'h1234_5678, 0, 0, "sra0");

      // Backpressure: result held, next op waits, then pop and accept on the same edge.
      op = 4'd2; in1 = 32'd1; in2 = 32'd2; in_valid = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      op = 4'd2; in1 = 32'd10; in2 = 32'd20;
      for (int i = 0; i < 5; i++) begin
         chk("bp_hold", 64'(out), 64'(3));
         chk("bp_valid", 64'(out_valid), 64'(1));
         chk("bp_blk", 64'(in_ready), 64'(0));
         @(negedge clk);
      end
      out_ready = 1'b1;
      #1;
      chk("bp_rdy", 64'(in_ready), 64'(1));
      @(negedge clk);
      in_valid = 1'b0;
      chk("bp_next_v", 64'(out_valid), 64'(1));
      chk("bp_next_out", 64'(out), 64'(30));
      @(negedge clk);
      chk("bp_pop", 64'(out_valid), 64'(0));
      out_ready = 1'b0;

      run_op(4'd8, 32'd7, 32'd6, 0, 0, "mul76");
      run_op(4'd8, 32'hFFFF_FFFF, 32'd2, 0, 1, "mulneg");
      run_op(4'd12, 32'hDEAD_BEEF, 32'h1, 0, 0, "rsvd");

      // Reset pulsed mid-operation clears everything immediately.
      op = 4'd8; in1 = 32'd7; in2 = 32'd6; in_valid = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (10) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mrst_valid", 64'(out_valid), 64'(0));
      chk("mrst_out", 64'(out), 64'(0));
      chk("mrst_zero", 64'(zero), 64'(1));
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      run_op(4'd2, 32'd1, 32'd1, 0, 0, "post_rst");

      for (int n = 0; n < 60; n++) begin
         logic [W-1:0] a;
         logic [W-1:0] b;
         a = $urandom;
         b = $urandom;
         if ($urandom_range(0, 3) == 0) b = a;
         run_op(4'($urandom_range(0, 10)), a, b, int'($urandom_range(0, W - 1)),
                int'($urandom_range(0, 2)), "rnd");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
